// File: rtl/csr_file_if.sv
// CSR bundle: every architectural register value published by csr_file.
// Producer uses modport o (alias master); consumers use modport i (alias slave).
interface csr_reg;
  logic [31:0] crmd, prmd, euen, ecfg, estat, era, badv, eentry;
  logic [31:0] tlbidx, tlbehi, tlbelo0, tlbelo1, asid, pgdl, pgdh, pgd;
  logic [31:0] cpuid, save0, save1, save2, save3, tid, tcfg, tval;
  logic [31:0] llbctl, tlbrentry, ctag, dmw0, dmw1;

  modport o (
    output crmd, prmd, euen, ecfg, estat, era, badv, eentry,
           tlbidx, tlbehi, tlbelo0, tlbelo1, asid, pgdl, pgdh, pgd,
           cpuid, save0, save1, save2, save3, tid, tcfg, tval,
           llbctl, tlbrentry, ctag, dmw0, dmw1
  );
  modport i (
    input crmd, prmd, euen, ecfg, estat, era, badv, eentry,
          tlbidx, tlbehi, tlbelo0, tlbelo1, asid, pgdl, pgdh, pgd,
          cpuid, save0, save1, save2, save3, tid, tcfg, tval,
          llbctl, tlbrentry, ctag, dmw0, dmw1
  );
  modport master (
    output crmd, prmd, euen, ecfg, estat, era, badv, eentry,
           tlbidx, tlbehi, tlbelo0, tlbelo1, asid, pgdl, pgdh, pgd,
           cpuid, save0, save1, save2, save3, tid, tcfg, tval,
           llbctl, tlbrentry, ctag, dmw0, dmw1
  );
  modport slave (
    input crmd, prmd, euen, ecfg, estat, era, badv, eentry,
          tlbidx, tlbehi, tlbelo0, tlbelo1, asid, pgdl, pgdh, pgd,
          cpuid, save0, save1, save2, save3, tid, tcfg, tval,
          llbctl, tlbrentry, ctag, dmw0, dmw1
  );
endinterface

// File: rtl/csr_file.sv
// LoongArch CSR file: masked read/write port, exception/ertn side effects, interrupt sampling.
// Optional stable timer (TID/TCFG/TVAL/TICLR) is built only when CSR_TIMER_EN is defined.
module csr_file #(
  parameter int unsigned CPU_ID = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [13:0] rd_addr,
  output logic [31:0] rd_data,
  input  logic        we,
  input  logic [13:0] wr_addr,
  input  logic [31:0] wr_data,
  input  logic [31:0] wr_mask,
  input  logic        excp_valid,
  input  logic [5:0]  ecode,
  input  logic [8:0]  esubcode,
  input  logic [31:0] excp_pc,
  input  logic        badv_valid,
  input  logic [31:0] badv_value,
  input  logic        ertn_valid,
  input  logic [7:0]  hw_int,
  input  logic        ipi,
  csr_reg.o           csr,
  output logic        int_pending
);
  localparam int unsigned AW = 14;
  localparam int unsigned DW = 32;

  localparam logic [AW-1:0] A_CRMD = 14'h0,   A_PRMD = 14'h1,   A_EUEN = 14'h2,   A_ECFG = 14'h4;
  localparam logic [AW-1:0] A_ESTAT = 14'h5,  A_ERA = 14'h6,    A_BADV = 14'h7,   A_EENTRY = 14'hC;
  localparam logic [AW-1:0] A_TLBIDX = 14'h10, A_TLBEHI = 14'h11, A_TLBELO0 = 14'h12, A_TLBELO1 = 14'h13;
  localparam logic [AW-1:0] A_ASID = 14'h18,  A_PGDL = 14'h19,  A_PGDH = 14'h1A,  A_PGD = 14'h1B;
  localparam logic [AW-1:0] A_CPUID = 14'h20, A_SAVE0 = 14'h30;
  localparam logic [AW-1:0] A_TID = 14'h40,   A_TCFG = 14'h41,  A_TVAL = 14'h42,  A_TICLR = 14'h44;
  localparam logic [AW-1:0] A_LLBCTL = 14'h60, A_TLBRENTRY = 14'h88, A_CTAG = 14'h98;
  localparam logic [AW-1:0] A_DMW0 = 14'h180, A_DMW1 = 14'h181;

  localparam logic [DW-1:0] W_ALL    = '1;
  localparam logic [DW-1:0] W_CRMD   = 32'h0000_01FF;
  localparam logic [DW-1:0] W_ESTAT  = 32'h0000_0003;
  localparam logic [DW-1:0] W_EENTRY = 32'hFFFF_FFC0;
  localparam logic [5:0]    ECODE_TLBR = 6'h3F;

  logic [DW-1:0] crmd_q, crmd_d, prmd_q, prmd_d, euen_q, euen_d, ecfg_q, ecfg_d;
  logic [DW-1:0] estat_q, estat_d, era_q, era_d, badv_q, badv_d, eentry_q, eentry_d;
  logic [DW-1:0] tlbidx_q, tlbidx_d, tlbehi_q, tlbehi_d, tlbelo0_q, tlbelo0_d, tlbelo1_q, tlbelo1_d;
  logic [DW-1:0] asid_q, asid_d, pgdl_q, pgdl_d, pgdh_q, pgdh_d;
  logic [DW-1:0] llbctl_q, llbctl_d, tlbrentry_q, tlbrentry_d, ctag_q, ctag_d;
  logic [DW-1:0] dmw0_q, dmw0_d, dmw1_q, dmw1_d;
  logic [DW-1:0] save_q [4];
  logic [DW-1:0] save_d [4];
  logic [DW-1:0] pgd_c, cpuid_c, tid_c, tcfg_c, tval_c;
  logic          is11_c;

  // Masked merge: only bits selected by mask change, and only when sel is set.
  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] data,
                                          input logic [DW-1:0] mask, input logic sel);
    logic [DW-1:0] m;
    m = sel ? mask : '0;
    return (old & ~m) | (data & m);
  endfunction

`ifdef CSR_TIMER_EN
  logic [DW-1:0] tid_q, tid_d, tcfg_q, tcfg_d, tval_q, tval_d;
  logic          tcfg_wr_c, timer_fire_c, ticlr_clr_c;

  always_comb begin
    tcfg_wr_c    = we && (wr_addr == A_TCFG);
    ticlr_clr_c  = we && (wr_addr == A_TICLR) && wr_mask[0] && wr_data[0];
    timer_fire_c = 1'b0;
    tid_d  = merge(tid_q, wr_data, wr_mask, we && (wr_addr == A_TID));
    tcfg_d = merge(tcfg_q, wr_data, wr_mask, tcfg_wr_c);
    tval_d = tval_q;
    if (tcfg_wr_c) begin
      tval_d = {tcfg_d[31:2], 2'b00};
    end else if (tcfg_q[0] && (tval_q != '0)) begin
      tval_d       = tval_q - 32'd1;
      timer_fire_c = (tval_q == 32'd1);
    end else if (tcfg_q[0] && tcfg_q[1]) begin
      tval_d = {tcfg_q[31:2], 2'b00};
    end
    // A timer expiry outranks a same-cycle TICLR clear.
    is11_c = timer_fire_c | (estat_q[11] & ~ticlr_clr_c);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tid_q  <= '0;
      tcfg_q <= '0;
      tval_q <= '0;
    end else begin
      tid_q  <= tid_d;
      tcfg_q <= tcfg_d;
      tval_q <= tval_d;
    end
  end

  assign tid_c  = tid_q;
  assign tcfg_c = tcfg_q;
  assign tval_c = tval_q;
`else
  assign tid_c  = '0;
  assign tcfg_c = '0;
  assign tval_c = '0;
  assign is11_c = 1'b0;
`endif

  assign pgd_c   = badv_q[31] ? pgdh_q : pgdl_q;
  assign cpuid_c = DW'(CPU_ID);

  // Next state: software write first, then ertn, then exception override the fields they own.
  always_comb begin
    crmd_d      = merge(crmd_q,      wr_data, wr_mask & W_CRMD,   we && (wr_addr == A_CRMD));
    prmd_d      = merge(prmd_q,      wr_data, wr_mask,            we && (wr_addr == A_PRMD));
    euen_d      = merge(euen_q,      wr_data, wr_mask,            we && (wr_addr == A_EUEN));
    ecfg_d      = merge(ecfg_q,      wr_data, wr_mask,            we && (wr_addr == A_ECFG));
    estat_d     = merge(estat_q,     wr_data, wr_mask & W_ESTAT,  we && (wr_addr == A_ESTAT));
    era_d       = merge(era_q,       wr_data, wr_mask,            we && (wr_addr == A_ERA));
    badv_d      = merge(badv_q,      wr_data, wr_mask,            we && (wr_addr == A_BADV));
    eentry_d    = merge(eentry_q,    wr_data, wr_mask & W_EENTRY, we && (wr_addr == A_EENTRY));
    tlbidx_d    = merge(tlbidx_q,    wr_data, wr_mask & W_ALL,    we && (wr_addr == A_TLBIDX));
    tlbehi_d    = merge(tlbehi_q,    wr_data, wr_mask,            we && (wr_addr == A_TLBEHI));
    tlbelo0_d   = merge(tlbelo0_q,   wr_data, wr_mask,            we && (wr_addr == A_TLBELO0));
    tlbelo1_d   = merge(tlbelo1_q,   wr_data, wr_mask,            we && (wr_addr == A_TLBELO1));
    asid_d      = merge(asid_q,      wr_data, wr_mask,            we && (wr_addr == A_ASID));
    pgdl_d      = merge(pgdl_q,      wr_data, wr_mask,            we && (wr_addr == A_PGDL));
    pgdh_d      = merge(pgdh_q,      wr_data, wr_mask,            we && (wr_addr == A_PGDH));
    llbctl_d    = merge(llbctl_q,    wr_data, wr_mask,            we && (wr_addr == A_LLBCTL));
    tlbrentry_d = merge(tlbrentry_q, wr_data, wr_mask,            we && (wr_addr == A_TLBRENTRY));
    ctag_d      = merge(ctag_q,      wr_data, wr_mask,            we && (wr_addr == A_CTAG));
    dmw0_d      = merge(dmw0_q,      wr_data, wr_mask,            we && (wr_addr == A_DMW0));
    dmw1_d      = merge(dmw1_q,      wr_data, wr_mask,            we && (wr_addr == A_DMW1));
    for (int i = 0; i < 4; i++) begin
      save_d[i] = merge(save_q[i], wr_data, wr_mask, we && (wr_addr == (A_SAVE0 + AW'(i))));
    end

    estat_d[9:2] = hw_int;
    estat_d[10]  = 1'b0;
    estat_d[11]  = is11_c;
    estat_d[12]  = ipi;

    if (excp_valid) begin
      prmd_d[1:0]    = crmd_q[1:0];
      prmd_d[2]      = crmd_q[2];
      crmd_d[2:0]    = 3'b000;
      era_d          = excp_pc;
      estat_d[21:16] = ecode;
      estat_d[30:22] = esubcode;
      if (badv_valid) badv_d = badv_value;
      if (ecode == ECODE_TLBR) begin
        crmd_d[3] = 1'b1;
        crmd_d[4] = 1'b0;
      end
    end else if (ertn_valid) begin
      crmd_d[1:0] = prmd_q[1:0];
      crmd_d[2]   = prmd_q[2];
      if (estat_q[21:16] == ECODE_TLBR) begin
        crmd_d[3] = 1'b0;
        crmd_d[4] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crmd_q <= 32'h0000_0008;
      prmd_q <= '0;  euen_q <= '0;  ecfg_q <= '0;  estat_q <= '0;
      era_q <= '0;   badv_q <= '0;  eentry_q <= '0;
      tlbidx_q <= '0;  tlbehi_q <= '0;  tlbelo0_q <= '0;  tlbelo1_q <= '0;
      asid_q <= '0;  pgdl_q <= '0;  pgdh_q <= '0;
      llbctl_q <= '0;  tlbrentry_q <= '0;  ctag_q <= '0;  dmw0_q <= '0;  dmw1_q <= '0;
      for (int i = 0; i < 4; i++) save_q[i] <= '0;
    end else begin
      crmd_q <= crmd_d;
      prmd_q <= prmd_d;  euen_q <= euen_d;  ecfg_q <= ecfg_d;  estat_q <= estat_d;
      era_q <= era_d;    badv_q <= badv_d;  eentry_q <= eentry_d;
      tlbidx_q <= tlbidx_d;  tlbehi_q <= tlbehi_d;  tlbelo0_q <= tlbelo0_d;  tlbelo1_q <= tlbelo1_d;
      asid_q <= asid_d;  pgdl_q <= pgdl_d;  pgdh_q <= pgdh_d;
      llbctl_q <= llbctl_d;  tlbrentry_q <= tlbrentry_d;  ctag_q <= ctag_d;
      dmw0_q <= dmw0_d;  dmw1_q <= dmw1_d;
      for (int i = 0; i < 4; i++) save_q[i] <= save_d[i];
    end
  end

  always_comb begin
    rd_data = '0;
    case (rd_addr)
      A_CRMD:      rd_data = crmd_q;
      A_PRMD:      rd_data = prmd_q;
      A_EUEN:      rd_data = euen_q;
      A_ECFG:      rd_data = ecfg_q;
      A_ESTAT:     rd_data = estat_q;
      A_ERA:       rd_data = era_q;
      A_BADV:      rd_data = badv_q;
      A_EENTRY:    rd_data = eentry_q;
      A_TLBIDX:    rd_data = tlbidx_q;
      A_TLBEHI:    rd_data = tlbehi_q;
      A_TLBELO0:   rd_data = tlbelo0_q;
      A_TLBELO1:   rd_data = tlbelo1_q;
      A_ASID:      rd_data = asid_q;
      A_PGDL:      rd_data = pgdl_q;
      A_PGDH:      rd_data = pgdh_q;
      A_PGD:       rd_data = pgd_c;
      A_CPUID:     rd_data = cpuid_c;
      14'h30:      rd_data = save_q[0];
      14'h31:      rd_data = save_q[1];
      14'h32:      rd_data = save_q[2];
      14'h33:      rd_data = save_q[3];
      A_TID:       rd_data = tid_c;
      A_TCFG:      rd_data = tcfg_c;
      A_TVAL:      rd_data = tval_c;
      A_TICLR:     rd_data = '0;
      A_LLBCTL:    rd_data = llbctl_q;
      A_TLBRENTRY: rd_data = tlbrentry_q;
      A_CTAG:      rd_data = ctag_q;
      A_DMW0:      rd_data = dmw0_q;
      A_DMW1:      rd_data = dmw1_q;
      default:     rd_data = '0;
    endcase
  end

  assign int_pending = crmd_q[2] & (|(estat_q[12:0] & ecfg_q[12:0]));

  assign csr.crmd = crmd_q;     assign csr.prmd = prmd_q;       assign csr.euen = euen_q;
  assign csr.ecfg = ecfg_q;     assign csr.estat = estat_q;     assign csr.era = era_q;
  assign csr.badv = badv_q;     assign csr.eentry = eentry_q;   assign csr.tlbidx = tlbidx_q;
  assign csr.tlbehi = tlbehi_q; assign csr.tlbelo0 = tlbelo0_q; assign csr.tlbelo1 = tlbelo1_q;
  assign csr.asid = asid_q;     assign csr.pgdl = pgdl_q;       assign csr.pgdh = pgdh_q;
  assign csr.pgd = pgd_c;       assign csr.cpuid = cpuid_c;     assign csr.save0 = save_q[0];
  assign csr.save1 = save_q[1]; assign csr.save2 = save_q[2];   assign csr.save3 = save_q[3];
  assign csr.tid = tid_c;       assign csr.tcfg = tcfg_c;       assign csr.tval = tval_c;
  assign csr.llbctl = llbctl_q; assign csr.tlbrentry = tlbrentry_q;
  assign csr.ctag = ctag_q;     assign csr.dmw0 = dmw0_q;       assign csr.dmw1 = dmw1_q;
endmodule

// File: tb/tb_csr_file.sv
// Scoreboard bench for csr_file: stimulus queues expected read/interrupt values, a negedge monitor checks them.
module tb_csr_file;
  localparam int unsigned TB_CPU_ID = 5;

  logic        clk, rst_n;
  logic [13:0] rd_addr, wr_addr;
  logic [31:0] rd_data, wr_data, wr_mask, excp_pc, badv_value;
  logic        we, excp_valid, badv_valid, ertn_valid, ipi, int_pending;
  logic [5:0]  ecode;
  logic [8:0]  esubcode;
  logic [7:0]  hw_int;

  csr_reg csr_if ();

  csr_file #(.CPU_ID(TB_CPU_ID)) dut (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data),
    .we(we), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask),
    .excp_valid(excp_valid), .ecode(ecode), .esubcode(esubcode), .excp_pc(excp_pc),
    .badv_valid(badv_valid), .badv_value(badv_value), .ertn_valid(ertn_valid),
    .hw_int(hw_int), .ipi(ipi), .csr(csr_if), .int_pending(int_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        is_irq;
    logic [31:0] exp;
  } exp_t;

  exp_t  exp_q  [$];
  string name_q [$];
  int    checks = 0;
  int    errors = 0;

  // Monitor: every pending expectation refers to the outputs of the current cycle.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t        e;
      string       n;
      logic [31:0] act;
      e   = exp_q.pop_front();
      n   = name_q.pop_front();
      act = e.is_irq ? {31'b0, int_pending} : rd_data;
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h", n, act, e.exp);
      end
    end
  end

  task automatic expect_rd(input logic [13:0] a, input logic [31:0] e, input string n);
    rd_addr = a;
    exp_q.push_back('{is_irq: 1'b0, exp: e});
    name_q.push_back(n);
  endtask

  task automatic expect_irq(input logic e, input string n);
    exp_q.push_back('{is_irq: 1'b1, exp: {31'b0, e}});
    name_q.push_back(n);
  endtask

  task automatic wr(input logic [13:0] a, input logic [31:0] d, input logic [31:0] m);
    we = 1'b1; wr_addr = a; wr_data = d; wr_mask = m;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    we = 1'b0; excp_valid = 1'b0; ertn_valid = 1'b0; badv_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; rd_addr = '0; wr_addr = '0; wr_data = '0; wr_mask = '0; we = 1'b0;
    excp_valid = 1'b0; ecode = '0; esubcode = '0; excp_pc = '0; badv_valid = 1'b0;
    badv_value = '0; ertn_valid = 1'b0; hw_int = '0; ipi = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    expect_rd(14'h0, 32'h8, "in_reset_crmd");
    step();
    rst_n = 1'b1;

    expect_rd(14'h0, 32'h8, "rst_crmd"); expect_irq(1'b0, "rst_irq"); step();
    expect_rd(14'h20, 32'(TB_CPU_ID), "rst_cpuid"); step();

    // csrxchg with partial mask; no same-cycle bypass.
    wr(14'h0, 32'h7, 32'h4); expect_rd(14'h0, 32'h8, "xchg_same"); step();
    expect_rd(14'h0, 32'hC, "xchg_next"); step();

    wr(14'h0, 32'h7, 32'hFFFF_FFFF); step();
    expect_rd(14'h0, 32'h7, "crmd_7");
    excp_valid = 1'b1; ecode = 6'h8; esubcode = 9'h0; excp_pc = 32'h1C00_0100;
    badv_valid = 1'b1; badv_value = 32'h8000_1234;
    wr(14'h0, 32'h3, 32'h7);
    step();
    expect_rd(14'h0, 32'h0, "excp_crmd"); step();
    expect_rd(14'h1, 32'h7, "excp_prmd"); step();
    expect_rd(14'h6, 32'h1C00_0100, "excp_era"); step();
    expect_rd(14'h5, 32'h0008_0000, "excp_estat"); step();
    expect_rd(14'h7, 32'h8000_1234, "excp_badv"); wr(14'h1A, 32'h0ABC_0000, 32'hFFFF_FFFF); step();
    expect_rd(14'h1B, 32'h0ABC_0000, "pgd_high"); step();

    ertn_valid = 1'b1; expect_rd(14'h0, 32'h0, "ertn_same"); step();
    expect_rd(14'h0, 32'h7, "ertn_crmd"); step();

    // TLB refill entry and return toggle DA/PG.
    excp_valid = 1'b1; ecode = 6'h3F; step();
    expect_rd(14'h0, 32'h8, "tlbr_crmd"); step();
    expect_rd(14'h7, 32'h8000_1234, "badv_kept"); ertn_valid = 1'b1; step();
    expect_rd(14'h0, 32'h17, "tlbr_ertn_crmd"); step();

    // External interrupt line 0 -> IS[2], one cycle latency.
    wr(14'h4, 32'h4, 32'hFFFF_FFFF); step();
    hw_int = 8'h01; expect_irq(1'b0, "hwint_before"); step();
    expect_rd(14'h5, 32'h003F_0004, "hwint_estat"); expect_irq(1'b1, "hwint_irq");
    hw_int = 8'h00; step();
    expect_irq(1'b0, "hwint_drop"); step();

    // Only IS[1:0] of ESTAT is software writable; ipi lands in IS[12].
    wr(14'h5, 32'hFFFF_FFFF, 32'hFFFF_FFFF); ipi = 1'b1; step();
    expect_rd(14'h5, 32'h003F_1003, "estat_wr"); ipi = 1'b0; step();
    wr(14'hC, 32'hFFFF_FFFF, 32'hFFFF_FFFF); step();
    expect_rd(14'hC, 32'hFFFF_FFC0, "eentry_low"); step();
    wr(14'h3, 32'hFFFF_FFFF, 32'hFFFF_FFFF); step();
    expect_rd(14'h3, 32'h0, "unmapped"); wr(14'h20, 32'hFFFF_FFFF, 32'hFFFF_FFFF); step();
    expect_rd(14'h20, 32'(TB_CPU_ID), "cpuid_ro"); wr(14'h32, 32'hDEAD_BEEF, 32'hFFFF_FFFF); step();
    expect_rd(14'h32, 32'hDEAD_BEEF, "save2"); wr(14'h32, 32'h0, 32'h0000_FFFF); step();
    expect_rd(14'h32, 32'hDEAD_0000, "save2_mask"); step();
    expect_rd(14'h44, 32'h0, "ticlr_rd"); step();

`ifdef CSR_TIMER_EN
    wr(14'h4, 32'h800, 32'hFFFF_FFFF); step();
    wr(14'h41, 32'hB, 32'hFFFF_FFFF); expect_rd(14'h42, 32'h0, "tval_pre"); step();
    for (int i = 0; i <= 8; i++) begin
      expect_rd(14'h42, 32'(8 - i), "tval_per"); expect_irq(i == 8, "timer_irq"); step();
    end
    expect_rd(14'h42, 32'h8, "tval_reload"); expect_irq(1'b1, "timer_irq_hold"); step();
    expect_rd(14'h42, 32'h7, "tval_after"); wr(14'h44, 32'h1, 32'hFFFF_FFFF); step();
    expect_rd(14'h42, 32'h6, "tval_6"); expect_irq(1'b0, "ticlr_irq"); wr(14'h41, 32'h9, 32'hFFFF_FFFF); step();
    for (int i = 0; i <= 9; i++) begin
      expect_rd(14'h42, (i < 8) ? 32'(8 - i) : 32'h0, "tval_one");
      expect_irq(i >= 8, "oneshot_irq");
      if (i == 7) wr(14'h44, 32'h1, 32'hFFFF_FFFF);
      step();
    end
    expect_rd(14'h41, 32'h9, "tcfg_rd"); step();
`else
    wr(14'h41, 32'hB, 32'hFFFF_FFFF); step();
    expect_rd(14'h41, 32'h0, "tcfg_off"); step();
    expect_rd(14'h42, 32'h0, "tval_off"); expect_irq(1'b0, "irq_off"); step();
`endif

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
